down_count_32: RTL
==================

# down_count_32

Loadable 5-bit down-counter for the audio path. It is the counting-down companion to the 5-bit up-counter: it counts from a loaded value to zero on enable ticks and flags expiry. The sequencer uses it to time note durations (one-shot) and fixed tick intervals (periodic). It runs from the single system clock; `en` is a one-cycle tick strobe from the existing dividers.

## Interface
- `WIDTH`, default 5 — counter width; all values below are for the default.
- `clk`  in  1  system clock, all state updates on rising edge
- `clr`  in  1  reset; synchronous, active-high; highest priority
- `en`  in  1  count tick; one decrement per cycle it is high while running
- `load`  in  1  load strobe; captures `load_val`
- `load_val`  in  WIDTH  start/reload value
- `periodic`  in  1  mode: 1 = reload on expiry, 0 = one-shot stop at zero
- `out`  out  WIDTH  current count
- `busy`  out  1  high while in RUN
- `done`  out  1  one-cycle expiry pulse

## Operation
- **Registers:** `out`, `reload` (WIDTH bits, last loaded value), `state` (IDLE/RUN), `done`. All outputs are registered.
- **Reset (`clr`=1 at an edge):** `out`=0, `reload`=0, state=IDLE, `busy`=0, `done`=0. This overrides `load` and `en`, including mid-count.
- **Priority per edge:** `clr` > `load` > `en` tick > hold.
- **`load`=1:**
  - `out`←`load_val` and `reload`←`load_val`; `done`←0.
  - If `load_val`≠0, state←RUN.
  - If `load_val`=0, state←IDLE with no `done` pulse.
  - Legal in either state; it restarts a running count.
- **RUN, `en`=1, `load`=0:**
  - If `out`>1: `out`←`out`−1.
  - If `out`=1 (expiry): `done`←1.
    - With `periodic`=1: `out`←`reload`, stay in RUN.
    - With `periodic`=0: `out`←0, state←IDLE.
- **RUN, `en`=0:** hold `out`.
- **IDLE:** `en` is ignored and `out` holds. The counter never wraps below zero, unlike the up-counter, which wraps.
- **`done`:** high for exactly one cycle after each expiry edge, and 0 on every other edge.
- **`periodic`:** sampled only at the expiry edge. Changing it mid-count affects the next expiry.
- **`busy`:** equals (state==RUN).
- **Arithmetic:** unsigned WIDTH-bit values; maximum load is 31.

## Timing
- **Load:** the load at edge N makes `out`=`load_val` and `busy`=1 visible after edge N.
- **One-shot, `en` held high from edge N+1:**
  - `out` goes L−1, …, 1 on edges N+1 … N+L−1.
  - At edge N+L, `out`=0, `done`=1 and `busy`=0 together.
  - `done` drops after edge N+L+1.
- **Period:** in periodic mode, expiry occurs every L `en` ticks. During the `done` cycle `out`=L, not 0.
- **Gapped `en`:** expiry occurs after exactly L high-`en` edges, regardless of gaps.
- **Load with `en` on the same edge:** `load` wins and no decrement happens that edge.
- **Load on the expiry edge:** `load` wins, so there is no `done` pulse and the new value is taken.
- **`clr` in the cycle `done` is high:** `done` is 0 after that edge.
- **L=1:** expiry on the first `en` edge after the load.

## Test plan
- **Reset:** assert `clr` for 2 cycles with `load`=1, `load_val`=9, `en`=1 → `out`=0, `busy`=0, `done`=0 throughout and after.
- **One-shot:**
  - Stimulus: load 5, `periodic`=0, `en`=1 continuously.
  - Required: `out` 5,4,3,2,1,0; `done`=1 only in the cycle `out`=0; `busy` falls the same edge.
  - Follow-up: 10 more `en` cycles → `out` stays 0, `done` stays 0.
- **Periodic:**
  - Stimulus: load 3, `periodic`=1, `en`=1 for 12 cycles.
  - Required: `out` 3,2,1,3,2,1,…; `done` high exactly on each return to 3 (4 pulses); `busy` stays 1.
  - Mode change: drop `periodic` mid-run → next expiry lands on 0 and goes IDLE.
- **Gapped ticks:**
  - Stimulus: load 31, `en` high every 3rd cycle.
  - Required: `done` after exactly 31 `en` pulses (cycle 93 after the load), never earlier.
- **Collisions:**
  - Load 4 with `en`=1 on the same edge → `out`=4, not 3.
  - Load 7 on the expiry edge of a count of 2 → no `done`, `out`=7, `busy`=1.
  - Load 0 → IDLE, `busy`=0, no `done`.
- **Restart mid-count:** `clr` at `out`=2 during a count of 6 → `out`=0, IDLE; subsequent `en` has no effect until the next `load`.

Source files
------------

// File: rtl/down_count_32.sv
// down_count_32: loadable WIDTH-bit down-counter with one-shot and periodic modes.
// Counts from a loaded value to zero on enable ticks and pulses done on expiry.
//
// Ports:
//   clk      in         system clock, rising edge
//   clr      in         synchronous active-high reset, highest priority
//   en       in         count tick; one decrement per high cycle while running
//   load     in         load strobe; captures load_val and (re)starts the count
//   load_val in  WIDTH  start/reload value
//   periodic in         1 = reload on expiry, 0 = stop at zero
//   out      out WIDTH  current count
//   busy     out        high while running
//   done     out        one-cycle expiry pulse
module down_count_32 #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             periodic,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;

  // Expiry is the tick that would take the count from 1 to 0.
  logic expire_c;
  assign expire_c = (state_q == RUN) && en && (out_q == WIDTH'(1));

  // Single state/count register process; priority clr > load > tick > hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      out_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else if (load) begin
      out_q    <= load_val;
      reload_q <= load_val;
      done_q   <= 1'b0;
      // A zero load parks the counter without an expiry pulse.
      state_q  <= (load_val != '0) ? RUN : IDLE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (expire_c) begin
            done_q <= 1'b1;
            // periodic is only looked at here, so a mid-count change
            // takes effect on the next expiry.
            if (periodic) begin
              out_q <= reload_q;
            end else begin
              out_q   <= '0;
              state_q <= IDLE;
            end
          end else if (en) begin
            out_q <= out_q - WIDTH'(1);
          end
        end
        default: begin
          // IDLE: ticks ignored, count holds; never wraps below zero.
          out_q <= out_q;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule
